// File: rtl/diag_range_engine.sv
// SPI diagnostics engine: CPU halt/resume, config/status replies, and
// CRC-32 protected memory range reads and writes driven by SPI_Slave bytes.
module diag_range_engine #(
    parameter int ADDR_WIDTH   = 16,
    parameter int CONFIG_WIDTH = 4,
    parameter int MEM_LATENCY  = 1
) (
    input  logic                    fpga_clk,
    input  logic                    fpga_reset,
    input  logic                    rx_dv,
    input  logic [7:0]              rx_byte,
    output logic                    tx_dv,
    output logic [7:0]              tx_byte,
    input  logic                    spi_select,
    output logic                    halt,
    output logic [ADDR_WIDTH-1:0]   address,
    input  logic [7:0]              data,
    output logic [7:0]              data_out,
    output logic                    we,
    output logic                    cs,
    input  logic [CONFIG_WIDTH-1:0] configuration
);
    localparam int ADDR_BYTES = (ADDR_WIDTH + 7) / 8;
    localparam int HDR_BITS   = ADDR_BYTES * 8;

    localparam logic [7:0] CMD_HALT        = 8'hAA;
    localparam logic [7:0] CMD_RESUME      = 8'h55;
    localparam logic [7:0] CMD_READ_CONFIG = 8'h77;
    localparam logic [7:0] CMD_STATUS      = 8'h3C;
    localparam logic [7:0] CMD_READ_RANGE  = 8'h66;
    localparam logic [7:0] CMD_WRITE_RANGE = 8'h99;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
    localparam logic [3:0] HDR_LAST  = 4'(2 * ADDR_BYTES - 1);
    localparam logic [3:0] HDR_SPLIT = 4'(ADDR_BYTES);

    typedef enum logic [3:0] {
        ST_STARTUP,
        ST_RUNNING,
        ST_HALTED,
        ST_REPLY,
        ST_HDR,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_RD_NEXT,
        ST_WR_DATA,
        ST_WR_STROBE,
        ST_WR_HOLD,
        ST_CRC_SEND
    } state_t;

    state_t                  state, state_nxt;
    logic                    halt_nxt, tx_dv_nxt, we_nxt, cs_nxt;
    logic [7:0]              tx_byte_nxt, data_out_nxt;
    logic [ADDR_WIDTH-1:0]   address_nxt;
    logic [CONFIG_WIDTH-1:0] cfg_q, cfg_nxt;
    logic                    aborted_q, aborted_nxt, rejected_q, rejected_nxt;
    logic                    is_write_q, is_write_nxt;
    logic [3:0]              hdr_cnt_q, hdr_cnt_nxt;
    logic [HDR_BITS-1:0]     start_q, start_nxt, len_q, len_nxt;
    logic [ADDR_WIDTH:0]     count_q, count_nxt;
    logic [2:0]              wait_q, wait_nxt;
    logic [1:0]              crc_idx_q, crc_idx_nxt;
    logic [31:0]             crc_q, crc_nxt;

    logic [ADDR_WIDTH-1:0]   len_trunc;
    logic [ADDR_WIDTH:0]     len_count;
    logic [31:0]             crc_final;
    logic                    in_range_op;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] b);
        logic [31:0] c;
        c = crc_in ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [7:0] crc_sel(input logic [31:0] v, input logic [1:0] idx);
        logic [7:0] r;
        case (idx)
            2'd0:    r = v[31:24];
            2'd1:    r = v[23:16];
            2'd2:    r = v[15:8];
            default: r = v[7:0];
        endcase
        return r;
    endfunction

    // A zero length field encodes a full 2^ADDR_WIDTH byte sweep.
    assign len_trunc   = ADDR_WIDTH'({len_q, rx_byte});
    assign len_count   = (len_trunc == '0) ? {1'b1, {ADDR_WIDTH{1'b0}}} : {1'b0, len_trunc};
    assign crc_final   = ~crc_q;
    assign in_range_op = (state == ST_HDR) || (state == ST_RD_ISSUE) || (state == ST_RD_WAIT) ||
                         (state == ST_RD_NEXT) || (state == ST_WR_DATA) || (state == ST_WR_STROBE) ||
                         (state == ST_WR_HOLD) || (state == ST_CRC_SEND);

    always_comb begin
        state_nxt    = state;
        halt_nxt     = halt;
        tx_dv_nxt    = 1'b0;
        tx_byte_nxt  = tx_byte;
        we_nxt       = 1'b0;
        cs_nxt       = cs;
        data_out_nxt = data_out;
        address_nxt  = address;
        cfg_nxt      = cfg_q;
        aborted_nxt  = aborted_q;
        rejected_nxt = rejected_q;
        is_write_nxt = is_write_q;
        hdr_cnt_nxt  = hdr_cnt_q;
        start_nxt    = start_q;
        len_nxt      = len_q;
        count_nxt    = count_q;
        wait_nxt     = wait_q;
        crc_idx_nxt  = crc_idx_q;
        crc_nxt      = crc_q;

        // Host deselect beats any byte arriving in the same cycle.
        if (in_range_op && spi_select) begin
            state_nxt   = ST_HALTED;
            cs_nxt      = 1'b0;
            aborted_nxt = 1'b1;
        end else begin
            case (state)
                ST_STARTUP: begin
                    cfg_nxt      = configuration;
                    aborted_nxt  = 1'b0;
                    rejected_nxt = 1'b0;
                    state_nxt    = ST_RUNNING;
                end
                ST_RUNNING, ST_HALTED: begin
                    if (rx_dv) begin
                        case (rx_byte)
                            CMD_HALT: begin
                                if (state == ST_RUNNING) begin
                                    halt_nxt  = 1'b1;
                                    state_nxt = ST_HALTED;
                                end
                            end
                            CMD_RESUME: begin
                                if (state == ST_HALTED) begin
                                    halt_nxt  = 1'b0;
                                    state_nxt = ST_RUNNING;
                                end
                            end
                            CMD_READ_CONFIG: begin
                                tx_dv_nxt   = 1'b1;
                                tx_byte_nxt = 8'(cfg_q);
                                state_nxt   = ST_REPLY;
                            end
                            CMD_STATUS: begin
                                tx_dv_nxt    = 1'b1;
                                tx_byte_nxt  = {halt, aborted_q, rejected_q, 5'b0};
                                aborted_nxt  = 1'b0;
                                rejected_nxt = 1'b0;
                                state_nxt    = ST_REPLY;
                            end
                            CMD_READ_RANGE, CMD_WRITE_RANGE: begin
                                if (state == ST_HALTED) begin
                                    is_write_nxt = (rx_byte == CMD_WRITE_RANGE);
                                    hdr_cnt_nxt  = '0;
                                    state_nxt    = ST_HDR;
                                end else begin
                                    rejected_nxt = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_REPLY: begin
                    state_nxt = halt ? ST_HALTED : ST_RUNNING;
                end
                ST_HDR: begin
                    if (rx_dv) begin
                        if (hdr_cnt_q == HDR_LAST) begin
                            address_nxt = ADDR_WIDTH'(start_q);
                            count_nxt   = len_count;
                            aborted_nxt = 1'b0;
                            crc_nxt     = 32'hFFFF_FFFF;
                            state_nxt   = is_write_q ? ST_WR_DATA : ST_RD_ISSUE;
                        end else begin
                            if (hdr_cnt_q < HDR_SPLIT) begin
                                start_nxt = HDR_BITS'({start_q, rx_byte});
                            end else begin
                                len_nxt = HDR_BITS'({len_q, rx_byte});
                            end
                            hdr_cnt_nxt = hdr_cnt_q + 4'd1;
                        end
                    end
                end
                ST_RD_ISSUE: begin
                    cs_nxt    = 1'b1;
                    wait_nxt  = 3'(MEM_LATENCY - 1);
                    state_nxt = ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (wait_q == '0) begin
                        tx_dv_nxt   = 1'b1;
                        tx_byte_nxt = data;
                        crc_nxt     = crc32_byte(crc_q, data);
                        state_nxt   = ST_RD_NEXT;
                    end else begin
                        wait_nxt = wait_q - 3'd1;
                    end
                end
                ST_RD_NEXT: begin
                    if (rx_dv) begin
                        count_nxt   = count_q - CNT_ONE;
                        address_nxt = address + ADDR_ONE;
                        if (count_q != CNT_ONE) begin
                            state_nxt = ST_RD_ISSUE;
                        end else begin
                            cs_nxt      = 1'b0;
                            tx_dv_nxt   = 1'b1;
                            tx_byte_nxt = crc_final[31:24];
                            crc_idx_nxt = 2'd0;
                            state_nxt   = ST_CRC_SEND;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (rx_dv) begin
                        data_out_nxt = rx_byte;
                        cs_nxt       = 1'b1;
                        we_nxt       = 1'b1;
                        crc_nxt      = crc32_byte(crc_q, rx_byte);
                        state_nxt    = ST_WR_STROBE;
                    end
                end
                ST_WR_STROBE: begin
                    cs_nxt    = 1'b0;
                    state_nxt = ST_WR_HOLD;
                end
                // Address is held one cycle past the strobe before advancing.
                ST_WR_HOLD: begin
                    address_nxt = address + ADDR_ONE;
                    count_nxt   = count_q - CNT_ONE;
                    if (count_q == CNT_ONE) begin
                        tx_dv_nxt   = 1'b1;
                        tx_byte_nxt = crc_final[31:24];
                        crc_idx_nxt = 2'd0;
                        state_nxt   = ST_CRC_SEND;
                    end else begin
                        state_nxt = ST_WR_DATA;
                    end
                end
                ST_CRC_SEND: begin
                    if (rx_dv) begin
                        if (crc_idx_q == 2'd3) begin
                            state_nxt = ST_HALTED;
                        end else begin
                            crc_idx_nxt = crc_idx_q + 2'd1;
                            tx_dv_nxt   = 1'b1;
                            tx_byte_nxt = crc_sel(crc_final, crc_idx_q + 2'd1);
                        end
                    end
                end
                default: state_nxt = ST_STARTUP;
            endcase
        end
    end

    always_ff @(posedge fpga_clk) begin
        if (!fpga_reset) begin
            state      <= ST_STARTUP;
            halt       <= 1'b0;
            tx_dv      <= 1'b0;
            tx_byte    <= '0;
            we         <= 1'b0;
            cs         <= 1'b0;
            data_out   <= '0;
            address    <= '0;
            cfg_q      <= '0;
            aborted_q  <= 1'b0;
            rejected_q <= 1'b0;
            is_write_q <= 1'b0;
            hdr_cnt_q  <= '0;
            start_q    <= '0;
            len_q      <= '0;
            count_q    <= '0;
            wait_q     <= '0;
            crc_idx_q  <= '0;
            crc_q      <= '0;
        end else begin
            state      <= state_nxt;
            halt       <= halt_nxt;
            tx_dv      <= tx_dv_nxt;
            tx_byte    <= tx_byte_nxt;
            we         <= we_nxt;
            cs         <= cs_nxt;
            data_out   <= data_out_nxt;
            address    <= address_nxt;
            cfg_q      <= cfg_nxt;
            aborted_q  <= aborted_nxt;
            rejected_q <= rejected_nxt;
            is_write_q <= is_write_nxt;
            hdr_cnt_q  <= hdr_cnt_nxt;
            start_q    <= start_nxt;
            len_q      <= len_nxt;
            count_q    <= count_nxt;
            wait_q     <= wait_nxt;
            crc_idx_q  <= crc_idx_nxt;
            crc_q      <= crc_nxt;
        end
    end
endmodule

// File: tb/tb_diag_range_engine.sv
// Scoreboard bench for diag_range_engine: a 16-bit instance (latency 2)
// and an 8-bit instance (latency 1) each backed by a simple memory model.
module tb_diag_range_engine;
    logic fpga_clk = 1'b0;
    always #5 fpga_clk = ~fpga_clk;

    logic       fpga_reset;
    logic       spi_select;
    logic [3:0] configuration;
    logic       rx_dv_a, rx_dv_b;
    logic [7:0] rx_byte_a, rx_byte_b;

    logic        tx_dv_a, halt_a, we_a, cs_a;
    logic [7:0]  tx_byte_a, data_a, data_out_a;
    logic [15:0] address_a;
    logic        tx_dv_b, halt_b, we_b, cs_b;
    logic [7:0]  tx_byte_b, data_b, data_out_b;
    logic [7:0]  address_b;

    diag_range_engine #(.ADDR_WIDTH(16), .CONFIG_WIDTH(4), .MEM_LATENCY(2)) dut_a (
        .fpga_clk(fpga_clk), .fpga_reset(fpga_reset), .rx_dv(rx_dv_a), .rx_byte(rx_byte_a),
        .tx_dv(tx_dv_a), .tx_byte(tx_byte_a), .spi_select(spi_select), .halt(halt_a),
        .address(address_a), .data(data_a), .data_out(data_out_a), .we(we_a), .cs(cs_a),
        .configuration(configuration)
    );

    diag_range_engine #(.ADDR_WIDTH(8), .CONFIG_WIDTH(4), .MEM_LATENCY(1)) dut_b (
        .fpga_clk(fpga_clk), .fpga_reset(fpga_reset), .rx_dv(rx_dv_b), .rx_byte(rx_byte_b),
        .tx_dv(tx_dv_b), .tx_byte(tx_byte_b), .spi_select(spi_select), .halt(halt_b),
        .address(address_b), .data(data_b), .data_out(data_out_b), .we(we_b), .cs(cs_b),
        .configuration(configuration)
    );

    // Read-only memory images; writes are observed on the bus instead of stored.
    logic [7:0] mem_a [0:65535];
    logic [7:0] mem_b [0:255];
    logic [7:0] pipe_a1, pipe_a2, pipe_b1;
    always @(posedge fpga_clk) begin
        pipe_a1 <= mem_a[address_a];
        pipe_a2 <= pipe_a1;
        pipe_b1 <= mem_b[address_b];
    end
    assign data_a = pipe_a2;
    assign data_b = pipe_b1;

    int cyc = 0;
    always @(posedge fpga_clk) cyc <= cyc + 1;

    logic [7:0]  exp_a[$], exp_b[$], got_a[$], got_b[$];
    int          got_a_cyc[$], we_cyc_a[$];
    logic [15:0] we_addr_a[$];
    logic [7:0]  we_data_a[$];
    int          dbl_tx = 0;
    logic        prev_tx_a = 1'b0, prev_tx_b = 1'b0;

    always @(negedge fpga_clk) begin
        if (tx_dv_a) begin
            got_a.push_back(tx_byte_a);
            got_a_cyc.push_back(cyc);
        end
        if (tx_dv_b) got_b.push_back(tx_byte_b);
        if (we_a && cs_a) begin
            we_addr_a.push_back(address_a);
            we_data_a.push_back(data_out_a);
            we_cyc_a.push_back(cyc);
        end
        if ((tx_dv_a && prev_tx_a) || (tx_dv_b && prev_tx_b)) dbl_tx <= dbl_tx + 1;
        prev_tx_a <= tx_dv_a;
        prev_tx_b <= tx_dv_b;
    end

    int checks = 0;
    int failures = 0;

    function automatic logic [31:0] crc32_ref(input logic [7:0] q[$]);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (q[i]) begin
            c = c ^ {24'h0, q[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic send(input bit to_b, input logic [7:0] b, output int at_cyc);
        @(posedge fpga_clk); #1;
        if (to_b) begin rx_byte_b = b; rx_dv_b = 1'b1; end
        else begin rx_byte_a = b; rx_dv_a = 1'b1; end
        at_cyc = cyc;
        @(posedge fpga_clk); #1;
        rx_dv_a = 1'b0;
        rx_dv_b = 1'b0;
        repeat (8) @(posedge fpga_clk);
    endtask

    task automatic push_crc(input bit to_b, input logic [31:0] c);
        logic [31:0] v;
        v = c;
        for (int i = 3; i >= 0; i--) begin
            if (to_b) exp_b.push_back(v[i*8 +: 8]);
            else exp_a.push_back(v[i*8 +: 8]);
        end
    endtask

    task automatic test_reset();
        fpga_reset = 1'b0;
        spi_select = 1'b0;
        configuration = 4'hA;
        rx_dv_a = 1'b0; rx_dv_b = 1'b0; rx_byte_a = '0; rx_byte_b = '0;
        repeat (3) @(posedge fpga_clk);
        #1;
        checks++;
        if ({halt_a, tx_dv_a, we_a, cs_a, address_a, data_out_a, tx_byte_a} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_a: got %b/%b/%b/%b %h %h %h, expected all zero",
                     halt_a, tx_dv_a, we_a, cs_a, address_a, data_out_a, tx_byte_a);
        end
        checks++;
        if ({halt_b, tx_dv_b, we_b, cs_b, address_b, data_out_b, tx_byte_b} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_b: outputs not all zero");
        end
        fpga_reset = 1'b1;
        got_a.delete(); got_a_cyc.delete(); got_b.delete();
    endtask

    task automatic test_read_config();
        int t, lat;
        exp_a.push_back(8'h0A);
        exp_b.push_back(8'h0A);
        send(1'b0, 8'h77, t);
        send(1'b1, 8'h77, lat);
        lat = (got_a_cyc.size() > 0) ? got_a_cyc[0] - t : -1;
        checks++;
        if (lat != 1) begin failures++; $display("[TB] FAIL reply_latency: got %0d expected 1", lat); end
        checks++;
        if (halt_a !== 1'b0 || cs_a !== 1'b0) begin
            failures++; $display("[TB] FAIL cfg_idle: halt %b cs %b, expected 0 0", halt_a, cs_a);
        end
        checks++;
        if (got_a.size() != exp_a.size() || got_b.size() != exp_b.size()) begin
            failures++; $display("[TB] FAIL cfg_count: got %0d/%0d expected 1/1", got_a.size(), got_b.size());
        end
        while (exp_a.size() > 0 && got_a.size() > 0) begin
            checks++;
            if (got_a[0] !== exp_a[0]) begin failures++; $display("[TB] FAIL cfg_a: got %h expected %h", got_a[0], exp_a[0]); end
            void'(got_a.pop_front()); void'(exp_a.pop_front());
        end
        while (exp_b.size() > 0 && got_b.size() > 0) begin
            checks++;
            if (got_b[0] !== exp_b[0]) begin failures++; $display("[TB] FAIL cfg_b: got %h expected %h", got_b[0], exp_b[0]); end
            void'(got_b.pop_front()); void'(exp_b.pop_front());
        end
        exp_a.delete(); got_a.delete(); got_a_cyc.delete(); exp_b.delete(); got_b.delete();
    endtask

    task automatic test_read_range();
        int t, hdr_cyc, lat;
        send(1'b0, 8'hAA, t);
        checks++;
        if (halt_a !== 1'b1) begin failures++; $display("[TB] FAIL halt: got %b expected 1", halt_a); end
        for (int i = 0; i < 9; i++) exp_a.push_back(8'h31 + 8'(i));
        push_crc(1'b0, 32'hCBF43926);
        exp_a.push_back(8'h80);
        send(1'b0, 8'h66, t); send(1'b0, 8'h00, t); send(1'b0, 8'h10, t); send(1'b0, 8'h00, t);
        send(1'b0, 8'h09, hdr_cyc);
        lat = (got_a_cyc.size() > 0) ? got_a_cyc[0] - hdr_cyc : -1;
        checks++;
        if (lat != 4) begin failures++; $display("[TB] FAIL read_latency: got %0d expected 4", lat); end
        for (int i = 0; i < 13; i++) send(1'b0, 8'h00, t);
        checks++;
        if (cs_a !== 1'b0 || halt_a !== 1'b1) begin
            failures++; $display("[TB] FAIL read_end: cs %b halt %b, expected 0 1", cs_a, halt_a);
        end
        send(1'b0, 8'h3C, t);
        checks++;
        if (got_a.size() != exp_a.size()) begin
            failures++; $display("[TB] FAIL read_count: got %0d expected %0d", got_a.size(), exp_a.size());
        end
        while (exp_a.size() > 0 && got_a.size() > 0) begin
            checks++;
            if (got_a[0] !== exp_a[0]) begin failures++; $display("[TB] FAIL read_byte: got %h expected %h", got_a[0], exp_a[0]); end
            void'(got_a.pop_front()); void'(exp_a.pop_front());
        end
        exp_a.delete(); got_a.delete(); got_a_cyc.delete();
    endtask

    task automatic test_write_range();
        int t, d_cyc, lat;
        logic [7:0]  wdat[$];
        logic [15:0] waddr[$];
        wdat  = '{8'h11, 8'h22, 8'h33, 8'h44};
        waddr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        push_crc(1'b0, crc32_ref(wdat));
        exp_a.push_back(8'h80);
        we_addr_a.delete(); we_data_a.delete(); we_cyc_a.delete();
        send(1'b0, 8'h99, t); send(1'b0, 8'hFF, t); send(1'b0, 8'hFE, t); send(1'b0, 8'h00, t); send(1'b0, 8'h04, t);
        send(1'b0, wdat[0], d_cyc);
        for (int i = 1; i < 4; i++) send(1'b0, wdat[i], t);
        for (int i = 0; i < 4; i++) send(1'b0, 8'h00, t);
        lat = (we_cyc_a.size() > 0) ? we_cyc_a[0] - d_cyc : -1;
        checks++;
        if (lat != 1) begin failures++; $display("[TB] FAIL we_latency: got %0d expected 1", lat); end
        checks++;
        if (we_addr_a.size() != 4) begin failures++; $display("[TB] FAIL we_cycles: got %0d expected 4", we_addr_a.size()); end
        for (int i = 0; i < 4 && i < we_addr_a.size(); i++) begin
            checks++;
            if (we_addr_a[i] !== waddr[i] || we_data_a[i] !== wdat[i]) begin
                failures++;
                $display("[TB] FAIL write_%0d: got %h=%h expected %h=%h", i, we_addr_a[i], we_data_a[i], waddr[i], wdat[i]);
            end
        end
        send(1'b0, 8'h3C, t);
        checks++;
        if (got_a.size() != exp_a.size()) begin
            failures++; $display("[TB] FAIL write_count: got %0d expected %0d", got_a.size(), exp_a.size());
        end
        while (exp_a.size() > 0 && got_a.size() > 0) begin
            checks++;
            if (got_a[0] !== exp_a[0]) begin failures++; $display("[TB] FAIL write_crc: got %h expected %h", got_a[0], exp_a[0]); end
            void'(got_a.pop_front()); void'(exp_a.pop_front());
        end
        exp_a.delete(); got_a.delete(); got_a_cyc.delete();
    endtask

    task automatic test_full_sweep8();
        int t;
        logic [7:0] all[$];
        for (int i = 0; i < 256; i++) begin
            all.push_back(mem_b[i]);
            exp_b.push_back(mem_b[i]);
        end
        push_crc(1'b1, crc32_ref(all));
        send(1'b1, 8'hAA, t);
        send(1'b1, 8'h66, t); send(1'b1, 8'h00, t); send(1'b1, 8'h00, t);
        for (int i = 0; i < 260; i++) send(1'b1, 8'h00, t);
        checks++;
        if (cs_b !== 1'b0 || halt_b !== 1'b1) begin
            failures++; $display("[TB] FAIL sweep_end: cs %b halt %b, expected 0 1", cs_b, halt_b);
        end
        checks++;
        if (got_b.size() != exp_b.size()) begin
            failures++; $display("[TB] FAIL sweep_count: got %0d expected %0d", got_b.size(), exp_b.size());
        end
        while (exp_b.size() > 0 && got_b.size() > 0) begin
            checks++;
            if (got_b[0] !== exp_b[0]) begin failures++; $display("[TB] FAIL sweep_byte: got %h expected %h", got_b[0], exp_b[0]); end
            void'(got_b.pop_front()); void'(exp_b.pop_front());
        end
        exp_b.delete(); got_b.delete();
    endtask

    task automatic test_abort();
        int t;
        for (int i = 0; i < 3; i++) exp_a.push_back(8'hA0 + 8'(i));
        exp_a.push_back(8'hC0);
        exp_a.push_back(8'h00);
        send(1'b0, 8'h66, t); send(1'b0, 8'h00, t); send(1'b0, 8'h20, t); send(1'b0, 8'h00, t); send(1'b0, 8'h05, t);
        send(1'b0, 8'h00, t); send(1'b0, 8'h00, t);
        checks++;
        if (cs_a !== 1'b1) begin failures++; $display("[TB] FAIL abort_pre_cs: got %b expected 1", cs_a); end
        @(posedge fpga_clk); #1;
        spi_select = 1'b1;
        @(posedge fpga_clk); #1;
        checks++;
        if (cs_a !== 1'b0 || we_a !== 1'b0 || halt_a !== 1'b1) begin
            failures++; $display("[TB] FAIL abort_cs: cs %b we %b halt %b, expected 0 0 1", cs_a, we_a, halt_a);
        end
        spi_select = 1'b0;
        send(1'b0, 8'h3C, t);
        send(1'b0, 8'h55, t);
        checks++;
        if (halt_a !== 1'b0) begin failures++; $display("[TB] FAIL resume: got %b expected 0", halt_a); end
        send(1'b0, 8'h3C, t);
        checks++;
        if (got_a.size() != exp_a.size()) begin
            failures++; $display("[TB] FAIL abort_count: got %0d expected %0d", got_a.size(), exp_a.size());
        end
        while (exp_a.size() > 0 && got_a.size() > 0) begin
            checks++;
            if (got_a[0] !== exp_a[0]) begin failures++; $display("[TB] FAIL abort_byte: got %h expected %h", got_a[0], exp_a[0]); end
            void'(got_a.pop_front()); void'(exp_a.pop_front());
        end
        exp_a.delete(); got_a.delete(); got_a_cyc.delete();
    endtask

    task automatic test_reject();
        int t;
        exp_a.push_back(8'h20);
        send(1'b0, 8'h66, t); send(1'b0, 8'h00, t); send(1'b0, 8'h10, t); send(1'b0, 8'h00, t); send(1'b0, 8'h02, t);
        checks++;
        if (cs_a !== 1'b0 || halt_a !== 1'b0) begin
            failures++; $display("[TB] FAIL reject_cs: cs %b halt %b, expected 0 0", cs_a, halt_a);
        end
        send(1'b0, 8'h3C, t);
        checks++;
        if (got_a.size() != exp_a.size()) begin
            failures++; $display("[TB] FAIL reject_count: got %0d expected %0d", got_a.size(), exp_a.size());
        end
        while (exp_a.size() > 0 && got_a.size() > 0) begin
            checks++;
            if (got_a[0] !== exp_a[0]) begin failures++; $display("[TB] FAIL reject_status: got %h expected %h", got_a[0], exp_a[0]); end
            void'(got_a.pop_front()); void'(exp_a.pop_front());
        end
        exp_a.delete(); got_a.delete(); got_a_cyc.delete();
    endtask

    task automatic test_reset_mid_write();
        int t;
        send(1'b0, 8'hAA, t);
        send(1'b0, 8'h99, t); send(1'b0, 8'h00, t); send(1'b0, 8'h40, t); send(1'b0, 8'h00, t); send(1'b0, 8'h03, t);
        @(posedge fpga_clk); #1;
        rx_byte_a = 8'h5A;
        rx_dv_a = 1'b1;
        @(posedge fpga_clk); #1;
        rx_dv_a = 1'b0;
        checks++;
        if (we_a !== 1'b1 || data_out_a !== 8'h5A) begin
            failures++; $display("[TB] FAIL midwrite_we: we %b data %h, expected 1 5a", we_a, data_out_a);
        end
        fpga_reset = 1'b0;
        @(posedge fpga_clk); #1;
        checks++;
        if ({halt_a, tx_dv_a, we_a, cs_a, address_a, data_out_a, tx_byte_a} !== '0) begin
            failures++;
            $display("[TB] FAIL midwrite_reset: got %b/%b/%b/%b %h %h %h, expected all zero",
                     halt_a, tx_dv_a, we_a, cs_a, address_a, data_out_a, tx_byte_a);
        end
        fpga_reset = 1'b1;
        got_a.delete(); got_a_cyc.delete();
        exp_a.push_back(8'h00);
        send(1'b0, 8'h3C, t);
        checks++;
        if (got_a.size() != 1 || got_a[0] !== 8'h00) begin
            failures++; $display("[TB] FAIL post_reset_status: got %0d bytes, expected one 00", got_a.size());
        end
        exp_a.delete(); got_a.delete(); got_a_cyc.delete();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem_a[i] = 8'h00;
        for (int i = 0; i < 9; i++) mem_a[16'h0010 + i] = 8'h31 + 8'(i);
        for (int i = 0; i < 5; i++) mem_a[16'h0020 + i] = 8'hA0 + 8'(i);
        for (int i = 0; i < 256; i++) mem_b[i] = 8'(i * 7 + 3);

        test_reset();
        test_read_config();
        test_read_range();
        test_write_range();
        test_full_sweep8();
        test_abort();
        test_reject();
        test_reset_mid_write();

        checks++;
        if (dbl_tx != 0) begin failures++; $display("[TB] FAIL tx_pulse_width: got %0d double pulses expected 0", dbl_tx); end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/diag_range_engine.md
# diag_range_engine

Parametrised successor to the SPI diagnostics controller. It sits between the existing byte-level `SPI_Slave` and the memory/bus arbiter. Over SPI it halts and resumes the CPU, returns configuration and status, and reads or writes an arbitrary memory range given as start address plus length. Both directions end with a standard CRC-32 of the transferred bytes. Address width and configuration width are parameters.

## Interface
- `ADDR_WIDTH`, 16: memory address width, 8..24. `ADDR_BYTES = (ADDR_WIDTH+7)/8`.
- `CONFIG_WIDTH`, 4: width of `configuration`, 1..8.
- `MEM_LATENCY`, 1: cycles from `address`/`cs` valid to `data` valid, 1..4.
- `fpga_clk  in  1`: single clock. All logic is on the rising edge.
- `fpga_reset  in  1`: reset, synchronous, active-low.
- `rx_dv  in  1`: one-cycle strobe from `SPI_Slave`; a byte was received.
- `rx_byte  in  8`: received byte; valid with `rx_dv`.
- `tx_dv  out  1`: one-cycle strobe that loads `tx_byte` into `SPI_Slave`.
- `tx_byte  out  8`: byte shifted out during the next SPI byte.
- `spi_select  in  1`: SPI chip select, active-low. High means the host deselected.
- `halt  out  1`: CPU halt request.
- `address  out  ADDR_WIDTH`: memory address.
- `data  in  8`: memory read data.
- `data_out  out  8`: memory write data.
- `we  out  1`: write strobe.
- `cs  out  1`: memory select. High only during range operations.
- `configuration  in  CONFIG_WIDTH`: board configuration straps.

## Operation
- **Commands**
  - 0xAA HALT
  - 0x55 RESUME
  - 0x77 READ_CONFIG
  - 0x3C STATUS
  - 0x66 READ_RANGE
  - 0x99 WRITE_RANGE
- **Range header.** Both range commands are followed by `ADDR_BYTES` start-address bytes, then `ADDR_BYTES` length bytes, each MSB first.
  - Address bits above `ADDR_WIDTH` are ignored.
  - Length 0 means 2^`ADDR_WIDTH` bytes.
  - The length counter is `ADDR_WIDTH+1` bits wide.
  - Addresses wrap modulo 2^`ADDR_WIDTH`.
- **States**
  - STARTUP → RUNNING: latch `configuration`, clear status.
  - RUNNING:
    - HALT → HALTED with `halt`=1.
    - READ_CONFIG and STATUS → REPLY.
    - Range commands are rejected: set status bit5, no memory access.
    - Other bytes are ignored.
  - HALTED:
    - RESUME → RUNNING with `halt`=0.
    - READ_CONFIG and STATUS → REPLY.
    - Range commands → HDR.
    - Other bytes are ignored.
  - REPLY: pulse `tx_dv` with the reply byte, return to the originating state.
    - READ_CONFIG reply: `configuration` zero-extended to 8 bits.
    - STATUS reply: bit7 = halted, bit6 = last range op aborted, bit5 = range cmd rejected, bits4:0 = 0. Reading STATUS clears bits 6:5.
  - HDR: collect header bytes. On the last one, load `address` = start, clear bit6, set CRC = 0xFFFFFFFF, then go to RD_ISSUE or WR_DATA.
  - RD_ISSUE / RD_WAIT:
    - `cs`=1, `we`=0.
    - Wait `MEM_LATENCY` cycles, then capture `data`.
    - Pulse `tx_dv` with the captured byte and update the CRC.
    - Go to RD_NEXT.
  - RD_NEXT: on `rx_dv` (the host clocking a byte):
    - Decrement the remaining count and increment `address`.
    - If count > 0 → RD_ISSUE; else `cs`=0 → CRC_SEND.
  - WR_DATA: on `rx_dv`:
    - `data_out` = `rx_byte`; `cs`=1, `we`=1 for exactly one cycle; update the CRC.
    - Then increment `address` and decrement the count.
    - At zero: `cs`=0 → CRC_SEND.
  - CRC_SEND: send the 4 bytes of ~CRC, MSB first.
    - The first byte is loaded immediately.
    - Each later byte is loaded on the next `rx_dv`.
    - The `rx_dv` after the 4th byte → HALTED.
- **CRC.** Reflected polynomial 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF. Computed bitwise and combinationally, 8 bits per cycle; no table ROM.
- **Abort.** `spi_select`=1 in HDR, any RD/WR state, or CRC_SEND → next cycle go to HALTED with `cs`=0, `we`=0, status bit6=1. `halt` stays 1.
- **Simultaneous events.** When `spi_select` rises in the same cycle as `rx_dv`, the abort wins and the byte is discarded.

## Timing
- **Reset.** `fpga_reset`=0 at a clock edge forces the following from the next cycle, including mid-operation:
  - `halt`, `tx_dv`, `we`, `cs` = 0
  - `address` = 0, `data_out` = 0, `tx_byte` = 0
  - state = STARTUP, status = 0
- **STARTUP to RUNNING** takes 1 cycle.
- **Reply latency.** `tx_dv` pulses exactly 1 cycle after the command's `rx_dv`.
- **Read latency.** First read-data `tx_dv` pulses `MEM_LATENCY`+2 cycles after the last header `rx_dv`. Each later byte follows its `rx_dv` by `MEM_LATENCY`+2 cycles.
- **Write strobe.** `we` rises 1 cycle after the data `rx_dv`. `address` and `data_out` are stable that cycle and the next.
- **Host sequences**
  - READ: header, then length+4 clock bytes. MISO carries the data bytes, then the CRC.
  - WRITE: header, then length data bytes, then 4 clock bytes. MISO carries the CRC.
- **Rate constraint.** Every `tx_dv` must precede the next SPI byte start. This holds when `fpga_clk` ≥ 16× `spi_clk`.
- **Pulse width.** `tx_dv` is never high for two consecutive cycles.

## Test plan
- Reset with `configuration`=4'hA, send 0x77 → `tx_byte`=0x0A one cycle after `rx_dv`; `halt`=0, `cs`=0.
- Send 0xAA, then 0x66 00 10 00 09 with mem[0x10..0x18]="123456789", then 13 clock bytes → data 31..39, then CB F4 39 26, state HALTED.
- In HALTED, send 0x99 FF FE 00 04 with data 11 22 33 44 → one-cycle `we` at addresses FFFE, FFFF, 0000, 0001; CRC bytes follow.
- With `ADDR_WIDTH`=8, send 0x66 00 00 → 256 data bytes from address 0x00..0xFF, then 4 CRC bytes.
- Raise `spi_select` after 2 of 5 read bytes → `cs`=0 next cycle; STATUS returns 0xC0; 0x55 → `halt`=0.
- Send 0x66 while RUNNING → no `cs`, STATUS returns 0x20. Pull `fpga_reset` low mid-write → all outputs 0 next cycle.
